// File: rtl/imul_ctrl_if.sv
// Stream handshakes between the multiplier controller and its producer/consumer.
// The master side drives the stream into the controller and accepts the product.
interface imul_ctrl_if;
    logic istream_val;
    logic istream_rdy;
    logic ostream_val;
    logic ostream_rdy;

    modport master (
        output istream_val,
        output ostream_rdy,
        input  istream_rdy,
        input  ostream_val
    );

    modport slave (
        input  istream_val,
        input  ostream_rdy,
        output istream_rdy,
        output ostream_val
    );
endinterface

// File: rtl/imul_ctrl.sv
// Controller for the iterative shift-add multiplier: one load cycle, NBITS
// add/shift iterations, then hold the product until the consumer takes it.
module imul_ctrl #(
    parameter int NBITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    imul_ctrl_if.slave  strm,
    input  logic        b_lsb,
    output logic        b_mux_sel,
    output logic        a_mux_sel,
    output logic        r_mux_sel,
    output logic        add_mux_sel,
    output logic        r_en,
    output logic        state_done,
    output logic        busy
);
    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          istream_rdy;
    logic          ostream_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Everything except add_mux_sel decodes from the state register alone.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        b_mux_sel   = 1'b1;
        a_mux_sel   = 1'b1;
        r_mux_sel   = 1'b1;
        add_mux_sel = 1'b0;
        r_en        = 1'b0;
        state_done  = 1'b0;
        busy        = 1'b0;
        case (state_q)
            IDLE: begin
                istream_rdy = 1'b1;
                b_mux_sel   = 1'b0;
                a_mux_sel   = 1'b0;
                r_mux_sel   = 1'b0;
                r_en        = 1'b1;
                if (strm.istream_val) begin
                    state_d = CALC;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                r_en        = 1'b1;
                add_mux_sel = b_lsb;
                busy        = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                ostream_val = 1'b1;
                state_done  = 1'b1;
                busy        = 1'b1;
                if (strm.ostream_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                cnt_d      = '0;
                state_done = 1'b1;
            end
        endcase
    end

    assign strm.istream_rdy = istream_rdy;
    assign strm.ostream_val = ostream_val;
endmodule

// File: tb/tb_imul_ctrl.sv
// Bench for imul_ctrl: a behavioural A/B/R datapath closes the loop so products
// can be compared against plain A*B arithmetic.
module tb_imul_ctrl;
    logic        clk;
    logic        rst;
    logic        b_lsb;
    logic        b_mux_sel, a_mux_sel, r_mux_sel, add_mux_sel, r_en, state_done, busy;
    logic [31:0] msg_a, msg_b;
    logic [31:0] dp_a = '0, dp_b = '0, dp_r = '0;
    int          errors = 0;
    int          checks = 0;

    imul_ctrl_if strm ();

    imul_ctrl #(.NBITS(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .strm        (strm.slave),
        .b_lsb       (b_lsb),
        .b_mux_sel   (b_mux_sel),
        .a_mux_sel   (a_mux_sel),
        .r_mux_sel   (r_mux_sel),
        .add_mux_sel (add_mux_sel),
        .r_en        (r_en),
        .state_done  (state_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: A shifts left, B shifts right, R accumulates A when selected.
    always @(posedge clk) begin
        if (!a_mux_sel) dp_a <= msg_a;
        else if (!state_done) dp_a <= dp_a << 1;
        if (!b_mux_sel) dp_b <= msg_b;
        else if (!state_done) dp_b <= dp_b >> 1;
        if (r_en) dp_r <= r_mux_sel ? (add_mux_sel ? dp_r + dp_a : dp_r) : 32'd0;
    end
    assign b_lsb = dp_b[0];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        logic [31:0] prod;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One full transaction with istream_val kept high and noisy while busy.
    task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input int hold, input logic [31:0] prod);
        int          k;
        int          addBad;
        int          holdBad;
        logic [31:0] captured;
        @(negedge clk);
        msg_a = a;
        msg_b = b;
        strm.istream_val = 1'b1;
        strm.ostream_rdy = 1'b0;
        checkOutput({name, "/rdy_idle"}, {31'd0, strm.istream_rdy}, 32'd1);
        @(negedge clk);
        checkOutput({name, "/busy_rdy"}, {30'd0, busy, strm.istream_rdy}, 32'd2);
        k = 0;
        addBad = 0;
        while (k <= 40 && !strm.ostream_val) begin
            if (k < 32 && add_mux_sel !== b[k]) addBad++;
            msg_a = $urandom;
            msg_b = $urandom;
            @(negedge clk);
            k++;
        end
        checkOutput({name, "/latency"}, k, 32);
        checkOutput({name, "/add_sel_pattern"}, addBad, 0);
        checkOutput({name, "/product"}, dp_r, prod);
        captured = dp_r;
        holdBad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!strm.ostream_val || strm.istream_rdy || dp_r !== captured) holdBad++;
        end
        if (hold > 0) checkOutput({name, "/backpressure"}, holdBad, 0);
        strm.ostream_rdy = 1'b1;
        @(negedge clk);
        strm.ostream_rdy = 1'b0;
        strm.istream_val = 1'b0;
        checkOutput({name, "/after_hs"}, {30'd0, strm.ostream_val, strm.istream_rdy}, 32'd1);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [31:0] ra, rb;
        logic [31:0] res[2];
        int          accCyc[2];
        int          nAcc, nRes;

        vecs[0] = '{32'd3, 32'd5, 0, 32'd15};
        vecs[1] = '{32'hFFFFFFFE, 32'd7, 0, 32'hFFFFFFF2};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000001};
        vecs[3] = '{32'h80000000, 32'd2, 0, 32'h00000000};
        vecs[4] = '{32'd6, 32'd9, 10, 32'd54};
        vecs[5] = '{32'h12345678, 32'd0, 0, 32'd0};

        rst = 1'b0;
        msg_a = '0;
        msg_b = '0;
        strm.istream_val = 1'b0;
        strm.ostream_rdy = 1'b0;
        #1;
        checkOutput("reset_outputs",
                    {23'd0, strm.ostream_val, strm.istream_rdy, busy, b_mux_sel, a_mux_sel,
                     r_mux_sel, add_mux_sel, r_en, state_done}, 32'b0_1_0_0_0_0_0_1_0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++)
            applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].prod);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            applyStimulus($sformatf("rand%0d", i), ra, rb, int'($urandom_range(0, 3)), ra * rb);
        end

        // Abort in the middle of the iterations; the outputs must fall back at once.
        @(negedge clk);
        msg_a = 32'd100;
        msg_b = 32'd100;
        strm.istream_val = 1'b1;
        @(negedge clk);
        strm.istream_val = 1'b0;
        repeat (17) @(negedge clk);
        checkOutput("mid_op_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("mid_op_reset",
                    {23'd0, strm.ostream_val, strm.istream_rdy, busy, b_mux_sel, a_mux_sel,
                     r_mux_sel, add_mux_sel, r_en, state_done}, 32'b0_1_0_0_0_0_0_1_0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus("after_reset", 32'd4, 32'd4, 0, 32'd16);

        // Both handshakes tied high: accepts must repeat every NBITS+2 cycles.
        @(negedge clk);
        msg_a = 32'd7;
        msg_b = 32'd8;
        strm.istream_val = 1'b1;
        strm.ostream_rdy = 1'b1;
        nAcc = 0;
        nRes = 0;
        res[0] = '0;
        res[1] = '0;
        accCyc[0] = 0;
        accCyc[1] = 0;
        for (int i = 0; i < 120 && nRes < 2; i++) begin
            if (strm.istream_rdy && strm.istream_val && nAcc < 2) begin
                accCyc[nAcc] = i;
                nAcc++;
            end else if (nAcc == 1) begin
                msg_a = 32'd0;
                msg_b = 32'd12345;
            end else if (nAcc == 2) begin
                strm.istream_val = 1'b0;
            end
            if (strm.ostream_val) begin
                res[nRes] = dp_r;
                nRes++;
            end
            @(negedge clk);
        end
        strm.istream_val = 1'b0;
        strm.ostream_rdy = 1'b0;
        checkOutput("b2b_results", nRes, 2);
        checkOutput("b2b_first", res[0], 32'd56);
        checkOutput("b2b_second", res[1], 32'd0);
        checkOutput("b2b_spacing", accCyc[1] - accCyc[0], 34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
